// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU: opcodes, FSM states, default width.
// Imported by alu_seq and seq_mult.
package alu_pkg;

  localparam int W_DEF = 6;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_MUL = 3'b101,
    OP_SHL = 3'b110,
    OP_ASR = 3'b111
  } op_t;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_CALC = 3'd1;
  localparam logic [2:0] ST_MUL  = 3'd2;
  localparam logic [2:0] ST_FIX  = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

  typedef enum logic [2:0] {
    IDLE = ST_IDLE,
    CALC = ST_CALC,
    MUL  = ST_MUL,
    FIX  = ST_FIX,
    DONE = ST_DONE
  } state_t;

endpackage

// File: rtl/seq_mult.sv
// Unsigned W x W shift-add multiplier, one partial product per step.
// Ports: iclk, rst (async low), ld, step, mcand_in, mplier_in, product, last.
module seq_mult
  import alu_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic           iclk,
  input  logic           rst,
  input  logic           ld,
  input  logic           step,
  input  logic [W-1:0]   mcand_in,
  input  logic [W-1:0]   mplier_in,
  output logic [2*W-1:0] product,
  output logic           last
);

  localparam int CW = $clog2(W + 1);

  logic [W-1:0]  mcand;
  logic [CW-1:0] cnt;
  logic [W:0]    sum;

  // Low half starts as the multiplier and drains out as the
  // accumulated high half shifts in from the top.
  assign sum  = {1'b0, product[2*W-1:W]}
              + (product[0] ? {1'b0, mcand} : '0);
  assign last = (cnt == CW'(W - 1));

  always_ff @(posedge iclk or negedge rst) begin
    if (!rst) begin
      mcand   <= '0;
      product <= '0;
      cnt     <= '0;
    end else if (ld) begin
      mcand   <= mcand_in;
      product <= {{W{1'b0}}, mplier_in};
      cnt     <= '0;
    end else if (step) begin
      product <= {sum, product[W-1:1]};
      cnt     <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Sequential signed ALU with iterative multiply and overflow flag.
// Ports: iclk, rst (async low), start, op, a, b -> z, oF, busy, done.
module alu_seq
  import alu_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic         iclk,
  input  logic         rst,
  input  logic         start,
  input  logic [2:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] z,
  output logic         oF,
  output logic         busy,
  output logic         done
);

  state_t         state;
  state_t         nxt;
  op_t            op_q;
  logic [W-1:0]   a_q;
  logic [W-1:0]   b_q;
  logic           sgn_q;
  logic           accept;
  logic           ld;
  logic           step;
  logic           last;
  logic [2*W-1:0] prod;
  logic [2*W-1:0] p;
  logic           mul_of;
  logic [W-1:0]   alu_z;
  logic           alu_f;

  function automatic logic [W-1:0] mag(input logic [W-1:0] v);
    return v[W-1] ? (~v + W'(1)) : v;
  endfunction

  assign accept = (state == IDLE) && start;
  assign ld     = accept && (op_t'(op) == OP_MUL);
  assign step   = (state == MUL);
  assign busy   = (state != IDLE);
  assign done   = (state == DONE);

  seq_mult #(.W(W)) u_mult (
    .iclk      (iclk),
    .rst       (rst),
    .ld        (ld),
    .step      (step),
    .mcand_in  (mag(a)),
    .mplier_in (mag(b)),
    .product   (prod),
    .last      (last)
  );

  // Result fits in W bits only if the top W+1 product bits agree.
  assign p      = sgn_q ? (~prod + (2*W)'(1)) : prod;
  assign mul_of = !((&p[2*W-1:W-1]) || !(|p[2*W-1:W-1]));

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: if (start) nxt = (op_t'(op) == OP_MUL) ? MUL : CALC;
      CALC: nxt = DONE;
      MUL:  if (last) nxt = FIX;
      FIX:  nxt = DONE;
      DONE: nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    alu_z = '0;
    alu_f = 1'b0;
    unique case (op_q)
      OP_ADD: begin
        alu_z = a_q + b_q;
        alu_f = (a_q[W-1] == b_q[W-1]) && (alu_z[W-1] != a_q[W-1]);
      end
      OP_SUB: begin
        alu_z = a_q - b_q;
        alu_f = (a_q[W-1] != b_q[W-1]) && (alu_z[W-1] != a_q[W-1]);
      end
      OP_AND: alu_z = a_q & b_q;
      OP_OR:  alu_z = a_q | b_q;
      OP_XOR: alu_z = a_q ^ b_q;
      OP_MUL: alu_z = '0;
      OP_SHL: begin
        alu_z = {a_q[W-2:0], 1'b0};
        alu_f = a_q[W-1] ^ a_q[W-2];
      end
      OP_ASR: alu_z = {a_q[W-1], a_q[W-1:1]};
      default: alu_z = '0;
    endcase
  end

  always_ff @(posedge iclk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= nxt;
  end

  always_ff @(posedge iclk or negedge rst) begin
    if (!rst) begin
      op_q  <= OP_ADD;
      a_q   <= '0;
      b_q   <= '0;
      sgn_q <= 1'b0;
    end else if (accept) begin
      op_q  <= op_t'(op);
      a_q   <= a;
      b_q   <= b;
      sgn_q <= a[W-1] ^ b[W-1];
    end
  end

  always_ff @(posedge iclk or negedge rst) begin
    if (!rst) begin
      z  <= '0;
      oF <= 1'b0;
    end else if (state == CALC) begin
      z  <= alu_z;
      oF <= alu_f;
    end else if (state == FIX) begin
      z  <= p[W-1:0];
      oF <= mul_of;
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed vector bench for alu_seq: table of ops plus
// start-during-busy and reset-during-multiply sequences.
module tb_alu_seq;
  import alu_pkg::*;

  localparam int W = W_DEF;

  logic         iclk  = 1'b0;
  logic         rst   = 1'b0;
  logic         start = 1'b0;
  logic [2:0]   op    = 3'b000;
  logic [W-1:0] a     = '0;
  logic [W-1:0] b     = '0;
  logic [W-1:0] z;
  logic         oF;
  logic         busy;
  logic         done;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] z;
    logic         f;
  } vec_t;

  localparam int NV = 16;
  vec_t tv[NV];

  alu_seq #(.W(W)) dut (
    .iclk  (iclk),
    .rst   (rst),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .z     (z),
    .oF    (oF),
    .busy  (busy),
    .done  (done)
  );

  always #5 iclk = ~iclk;

  task automatic chk(input string nm,
                     input logic [15:0] act,
                     input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  task automatic run(input string nm,
                     input logic [2:0] o,
                     input logic [W-1:0] x,
                     input logic [W-1:0] y,
                     input logic [W-1:0] ez,
                     input logic ef);
    int lat;
    int elat;
    elat = (o == OP_MUL) ? W + 1 : 1;
    @(negedge iclk);
    op = o; a = x; b = y; start = 1'b1;
    @(posedge iclk); #1;
    start = 1'b0;
    chk({nm, ".busy_acc"}, 16'(busy), 16'(1));
    lat = 0;
    while (!done && lat < 40) begin
      a = W'($urandom);
      b = W'($urandom);
      @(posedge iclk); #1;
      lat++;
    end
    chk({nm, ".lat"}, 16'(lat), 16'(elat));
    chk({nm, ".z"}, 16'(z), 16'(ez));
    chk({nm, ".oF"}, 16'(oF), 16'(ef));
    @(posedge iclk); #1;
    chk({nm, ".done_off"}, 16'(done), 16'(0));
    chk({nm, ".busy_off"}, 16'(busy), 16'(0));
  endtask

  initial begin
    int dn;
    int cyc;
    tv[0]  = '{OP_ADD, 6'd25,     6'd10,     6'b100011, 1'b1};
    tv[1]  = '{OP_SUB, 6'b100000, 6'd1,      6'b011111, 1'b1};
    tv[2]  = '{OP_SUB, 6'd5,      6'd7,      6'b111110, 1'b0};
    tv[3]  = '{OP_MUL, 6'd5,      6'b111010, 6'b100010, 1'b0};
    tv[4]  = '{OP_MUL, 6'b100000, 6'b111111, 6'b100000, 1'b1};
    tv[5]  = '{OP_MUL, 6'b111000, 6'd4,      6'b100000, 1'b0};
    tv[6]  = '{OP_AND, 6'h15,     6'h0F,     6'h05,     1'b0};
    tv[7]  = '{OP_OR,  6'h15,     6'h0F,     6'h1F,     1'b0};
    tv[8]  = '{OP_XOR, 6'h15,     6'h0F,     6'h1A,     1'b0};
    tv[9]  = '{OP_SHL, 6'h15,     6'h00,     6'h2A,     1'b1};
    tv[10] = '{OP_ASR, 6'b111010, 6'h00,     6'b111101, 1'b0};
    tv[11] = '{OP_ASR, 6'h15,     6'h00,     6'h0A,     1'b0};
    tv[12] = '{OP_ADD, 6'b111111, 6'd1,      6'd0,      1'b0};
    tv[13] = '{OP_MUL, 6'd7,      6'd7,      6'b110001, 1'b1};
    tv[14] = '{OP_MUL, 6'd0,      6'b111011, 6'd0,      1'b0};
    tv[15] = '{OP_MUL, 6'd31,     6'b111111, 6'b100001, 1'b0};

    #2;
    chk("rst.z",    16'(z),    16'(0));
    chk("rst.oF",   16'(oF),   16'(0));
    chk("rst.busy", 16'(busy), 16'(0));
    chk("rst.done", 16'(done), 16'(0));
    @(negedge iclk);
    rst = 1'b1;

    for (int i = 0; i < NV; i++)
      run($sformatf("v%0d", i), tv[i].op, tv[i].a, tv[i].b,
          tv[i].z, tv[i].f);

    // start re-pulsed mid-multiply with different operands
    @(negedge iclk);
    op = OP_MUL; a = 6'd5; b = 6'b111010; start = 1'b1;
    @(posedge iclk); #1;
    start = 1'b0;
    @(posedge iclk);
    @(posedge iclk);
    @(negedge iclk);
    op = OP_ADD; a = 6'd1; b = 6'd1; start = 1'b1;
    @(posedge iclk); #1;
    start = 1'b0;
    dn = 0;
    cyc = 3;
    for (int k = 0; k < 12; k++) begin
      if (done) begin
        dn++;
        chk("rep.done_at", 16'(cyc), 16'(W + 1));
        chk("rep.z", 16'(z), 16'(6'b100010));
        chk("rep.oF", 16'(oF), 16'(0));
      end
      @(posedge iclk); #1;
      cyc++;
    end
    chk("rep.pulses", 16'(dn), 16'(1));
    chk("rep.idle", 16'(busy), 16'(0));

    // asynchronous reset in the middle of a multiply
    @(negedge iclk);
    op = OP_MUL; a = 6'd7; b = 6'd7; start = 1'b1;
    @(posedge iclk); #1;
    start = 1'b0;
    repeat (3) @(posedge iclk);
    #3;
    chk("ar.busy_pre", 16'(busy), 16'(1));
    rst = 1'b0;
    #1;
    chk("ar.z",    16'(z),    16'(0));
    chk("ar.oF",   16'(oF),   16'(0));
    chk("ar.busy", 16'(busy), 16'(0));
    chk("ar.done", 16'(done), 16'(0));
    @(negedge iclk);
    rst = 1'b1;
    repeat (10) @(posedge iclk);
    #1;
    chk("ar.hold_z",    16'(z),    16'(0));
    chk("ar.hold_busy", 16'(busy), 16'(0));
    run("ar.xor", OP_XOR, 6'h15, 6'h0F, 6'h1A, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
